// File: rtl/riscv_mem_pkg.sv
// Shared types for the RV32I MEM-stage load/store unit.
// funct3 size/sign codes and the bus FSM state encoding.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for RV32I loads and stores on a 32-bit bus.
// Purely combinational; the caller decides which outputs matter.
module load_store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{a, 3'b000} +: 8];
  assign lane_h = rdata[{a[1], 4'b0000} +: 16];

  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    load_ext   = 32'h0;
    misaligned = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: begin
        be    = 4'b0001 << a;
        wdata = {4{sdata[7:0]}};
        if (funct3 == F3_B)
          load_ext = {{24{lane_b[7]}}, lane_b};
        else
          load_ext = {24'h0, lane_b};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << {a[1], 1'b0};
        wdata      = {2{sdata[15:0]}};
        misaligned = a[0];
        if (funct3 == F3_H)
          load_ext = {{16{lane_h[15]}}, lane_h};
        else
          load_ext = {16'h0, lane_h};
      end
      F3_W: begin
        be         = 4'hF;
        wdata      = sdata;
        load_ext   = rdata;
        misaligned = |a;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_avalon_master.sv
// RV32I MEM stage: runs loads/stores as Avalon-MM master cycles,
// stalling the pipeline until each completes.
module mem_stage_avalon_master
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iValid,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        funct3,
  input  logic [31:0]       ALUResult,
  input  logic [DATA_W-1:0] StoreData,
  input  logic [4:0]        instr5b,
  input  logic              MemtoReg,
  input  logic              RegWrite,
  output logic              Stall,
  output logic [DATA_W-1:0] oData,
  output logic [31:0]       oAddress,
  output logic [4:0]        oinstr5b,
  output logic              oMemtoReg,
  output logic              oRegWrite,
  output logic              oFault,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rd_q, rd_d;

  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ld;
  logic              al_mis;
  logic              mem_op;
  logic              bad_f3;
  logic              fault;

  load_store_align u_align (
    .funct3     (funct3),
    .a          (ALUResult[1:0]),
    .sdata      (StoreData),
    .rdata      (avm_readdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_ext   (al_ld),
    .misaligned (al_mis)
  );

  // Stores have no unsigned variants, so BU/HU are illegal for them.
  always_comb begin
    bad_f3 = 1'b1;
    unique case (funct3)
      F3_B, F3_H, F3_W: bad_f3 = 1'b0;
      F3_BU, F3_HU:     bad_f3 = MemWrite;
      default:          bad_f3 = 1'b1;
    endcase
  end

  assign mem_op = iValid & (MemRead | MemWrite);
  assign fault  = mem_op &
                  (al_mis | bad_f3 | (MemRead & MemWrite));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    Stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !fault) begin
          addr_d  = {ALUResult[ADDR_W-1:2], 2'b00};
          be_d    = al_be;
          wdata_d = MemWrite ? al_wdata : '0;
          rd_d    = MemRead;
          state_d = REQ;
          Stall   = 1'b1;
        end
      end
      REQ: begin
        Stall = 1'b1;
        if (!avm_waitrequest)
          state_d = rd_q ? RESP : DONE;
      end
      RESP: begin
        Stall = 1'b1;
        if (avm_readdatavalid) begin
          rdata_d = al_ld;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
    end
  end

  assign avm_address    = addr_q;
  assign avm_byteenable = be_q;
  assign avm_writedata  = wdata_q;
  assign avm_read       = (state_q == REQ) & rd_q;
  assign avm_write      = (state_q == REQ) & ~rd_q;

  assign oFault    = (state_q == IDLE) & fault;
  assign oData     = (state_q == DONE && rd_q) ? rdata_q : '0;
  assign oAddress  = ALUResult;
  assign oinstr5b  = instr5b;
  assign oMemtoReg = MemtoReg;
  assign oRegWrite = RegWrite & iValid & ~oFault;

endmodule
